// File: rtl/orn_sticky.sv
// orn_sticky: masked N-input OR with sticky capture and first-event index.
// Optional input synchronizer enabled by defining ORN_INSYNC_EN.
module orn_sticky #(
  parameter int WIDTH = 4,
  parameter int IDXW  = $clog2(WIDTH)
) (
  input  logic             ck,
  input  logic             rst,
  input  logic [WIDTH-1:0] i,
  input  logic [WIDTH-1:0] mask,
  input  logic             mode,
  input  logic             clr,
  output logic             q,
  output logic [WIDTH-1:0] sticky,
  output logic [IDXW-1:0]  first_idx,
  output logic             first_vld
);

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] e;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] sticky_n;
  logic [IDXW-1:0]  low;

`ifdef ORN_INSYNC_EN
  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;

  // Two-flop synchronizer so i may be asynchronous to ck
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= i;
      sync2 <= sync1;
    end
  end

  assign s = sync2;
`else
  assign s = i;
`endif

  // A clear only removes old state; a same-cycle event is kept
  assign e        = s & ~mask;
  assign base     = clr ? '0 : sticky;
  assign sticky_n = base | e;

  // Lowest set channel of the current event vector
  always_comb begin
    low = '0;
    for (int k = WIDTH - 1; k >= 0; k--) begin
      if (e[k]) low = IDXW'(k);
    end
  end

  // Summary, sticky flags and first-event record
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      q         <= 1'b0;
      sticky    <= '0;
      first_idx <= '0;
      first_vld <= 1'b0;
    end else begin
      sticky <= sticky_n;
      q      <= mode ? |sticky_n : |e;
      if (base == '0 && e != '0) begin
        first_vld <= 1'b1;
        first_idx <= low;
      end else if (clr && e == '0) begin
        first_vld <= 1'b0;
        first_idx <= '0;
      end
    end
  end

endmodule

// File: tb/tb_orn_sticky.sv
// tb_orn_sticky: directed checks of orn_sticky at WIDTH 4, 2, 17 and 64.
// Latency adapts to the ORN_INSYNC_EN build option.
module tb_orn_sticky;

`ifdef ORN_INSYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        ck = 1'b0;
  logic        rst;
  logic [3:0]  i4, m4;
  logic        mode4, clr4;
  logic        q4, fv4;
  logic [3:0]  st4;
  logic [1:0]  fi4;

  logic [63:0] iw;
  logic        modew, clrw;
  logic        q2, q17, q64;
  logic        fv2, fv17, fv64;
  logic [1:0]  st2;
  logic [16:0] st17;
  logic [63:0] st64;
  logic [0:0]  fi2;
  logic [4:0]  fi17;
  logic [5:0]  fi64;

  int checks = 0;
  int failures = 0;

  always #5 ck = ~ck;

  orn_sticky #(.WIDTH(4)) u4 (
    .ck(ck), .rst(rst), .i(i4), .mask(m4),
    .mode(mode4), .clr(clr4), .q(q4), .sticky(st4),
    .first_idx(fi4), .first_vld(fv4)
  );

  orn_sticky #(.WIDTH(2)) u2 (
    .ck(ck), .rst(rst), .i(iw[1:0]), .mask(2'b0),
    .mode(modew), .clr(clrw), .q(q2), .sticky(st2),
    .first_idx(fi2), .first_vld(fv2)
  );

  orn_sticky #(.WIDTH(17)) u17 (
    .ck(ck), .rst(rst), .i(iw[16:0]), .mask(17'b0),
    .mode(modew), .clr(clrw), .q(q17), .sticky(st17),
    .first_idx(fi17), .first_vld(fv17)
  );

  orn_sticky #(.WIDTH(64)) u64 (
    .ck(ck), .rst(rst), .i(iw), .mask(64'b0),
    .mode(modew), .clr(clrw), .q(q64), .sticky(st64),
    .first_idx(fi64), .first_vld(fv64)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge ck);
      #1;
    end
  endtask

  task automatic chk4(input string tag, input logic q,
                      input logic [3:0] st, input logic [1:0] fi,
                      input logic fv);
    check({tag, ".q"}, 64'(q4), 64'(q));
    check({tag, ".sticky"}, 64'(st4), 64'(st));
    check({tag, ".first_idx"}, 64'(fi4), 64'(fi));
    check({tag, ".first_vld"}, 64'(fv4), 64'(fv));
  endtask

  task automatic clear4();
    i4 = 4'b0;
    step(LAT);
    clr4 = 1'b1;
    step(1);
    clr4 = 1'b0;
  endtask

  task automatic pulse4(input logic [3:0] v);
    i4 = v;
    step(1);
    i4 = 4'b0;
    step(LAT - 1);
  endtask

  task automatic chkw(input int w, input int p);
    logic [63:0] one;
    logic [63:0] exp;
    logic        hit;
    logic [63:0] st;
    logic [63:0] fi;
    logic        fv;
    logic        q;
    one = 64'd1;
    hit = (p < w);
    exp = hit ? (one << p) : 64'd0;
    fi  = hit ? 64'(p) : 64'd0;
    case (w)
      2:  begin st = 64'(st2);  q = q2;  fv = fv2;  fi = 64'(fi2);  end
      17: begin st = 64'(st17); q = q17; fv = fv17; fi = 64'(fi17); end
      default: begin
        st = st64; q = q64; fv = fv64; fi = 64'(fi64);
      end
    endcase
    check($sformatf("w%0d.m%0d.p%0d.sticky", w, modew, p), st, exp);
    check($sformatf("w%0d.m%0d.p%0d.q", w, modew, p),
          64'(q), 64'(hit));
    check($sformatf("w%0d.m%0d.p%0d.vld", w, modew, p),
          64'(fv), 64'(hit));
    check($sformatf("w%0d.m%0d.p%0d.idx", w, modew, p),
          fi, hit ? 64'(p) : 64'd0);
  endtask

  initial begin
    rst   = 1'b1;
    i4    = 4'hF;
    m4    = 4'b0;
    mode4 = 1'b0;
    clr4  = 1'b0;
    iw    = 64'd0;
    modew = 1'b0;
    clrw  = 1'b1;
    step(3);
    chk4("reset", 1'b0, 4'h0, 2'd0, 1'b0);

    rst = 1'b0;
    step(LAT);
    chk4("release", 1'b1, 4'hF, 2'd0, 1'b1);

    clear4();
    chk4("clr0", 1'b0, 4'h0, 2'd0, 1'b0);

    m4 = 4'b0100;
    i4 = 4'b0100;
    step(LAT);
    chk4("live_masked", 1'b0, 4'h0, 2'd0, 1'b0);
    i4 = 4'b0110;
    step(LAT);
    chk4("live_hit", 1'b1, 4'b0010, 2'd1, 1'b1);
    i4 = 4'b0000;
    step(LAT);
    chk4("live_drop", 1'b0, 4'b0010, 2'd1, 1'b1);

    m4 = 4'b0;
    clear4();
    mode4 = 1'b1;
    pulse4(4'b0100);
    chk4("stk_p2", 1'b1, 4'b0100, 2'd2, 1'b1);
    step(2);
    chk4("stk_hold", 1'b1, 4'b0100, 2'd2, 1'b1);
    pulse4(4'b0001);
    chk4("stk_p0", 1'b1, 4'b0101, 2'd2, 1'b1);
    step(LAT);
    clr4 = 1'b1;
    step(1);
    clr4 = 1'b0;
    chk4("stk_clr", 1'b0, 4'b0000, 2'd0, 1'b0);

    i4 = 4'b1010;
    step(LAT);
    chk4("simul", 1'b1, 4'b1010, 2'd1, 1'b1);
    clear4();

    pulse4(4'b0001);
    step(LAT);
    chk4("pre_clr", 1'b1, 4'b0001, 2'd0, 1'b1);
    i4 = 4'b1000;
    step(LAT - 1);
    clr4 = 1'b1;
    step(1);
    clr4 = 1'b0;
    chk4("clr_evt", 1'b1, 4'b1000, 2'd3, 1'b1);
    m4 = 4'b1000;
    step(LAT + 1);
    chk4("mask_keep", 1'b1, 4'b1000, 2'd3, 1'b1);
    mode4 = 1'b0;
    step(1);
    chk4("mode0_q", 1'b0, 4'b1000, 2'd3, 1'b1);

    for (int m = 0; m < 2; m++) begin
      modew = m[0];
      for (int p = 0; p < 64; p++) begin
        iw = 64'd1 << p;
        step(LAT);
        chkw(2, p);
        chkw(17, p);
        chkw(64, p);
      end
    end
    iw = 64'd0;
    step(LAT);
    check("sweep_end.sticky", st64, 64'd0);
    check("sweep_end.vld", 64'(fv64), 64'd0);
    check("sweep_end.q", 64'(q64), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
